// File: rtl/mlsu_store_txn_sched_if.sv
// Handshake bundle between the store sequencer and its surroundings:
// request intake, AXI AW/B channels and the per-beat txn_ctrl stream.
interface mlsu_store_txn_sched_if #(
    parameter int AxiAddrWidth = 64,
    parameter int AxiDataWidth = 128,
    parameter int LenWidth     = 32
);
    localparam int LbnWidth = $clog2(AxiDataWidth / 4) + 1;

    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [AxiAddrWidth-1:0] req_addr_i;
    logic [LenWidth-1:0]     req_nbytes_i;

    logic                    aw_valid_o;
    logic                    aw_ready_i;
    logic [AxiAddrWidth-1:0] aw_addr_o;
    logic [7:0]              aw_len_o;
    logic [2:0]              aw_size_o;

    logic                    txn_valid_o;
    logic                    txn_ready_i;
    logic [AxiAddrWidth:0]   txn_addr_o;
    logic                    txn_is_head_o;
    logic [7:0]              txn_rmn_beat_o;
    logic [LbnWidth-1:0]     txn_lbn_o;
    logic                    txn_is_final_o;

    logic                    b_valid_i;
    logic                    b_ready_o;
    logic [1:0]              b_resp_i;

    modport master (
        input  req_valid_i, req_addr_i, req_nbytes_i, aw_ready_i, txn_ready_i,
               b_valid_i, b_resp_i,
        output req_ready_o, aw_valid_o, aw_addr_o, aw_len_o, aw_size_o,
               txn_valid_o, txn_addr_o, txn_is_head_o, txn_rmn_beat_o, txn_lbn_o,
               txn_is_final_o, b_ready_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_nbytes_i, aw_ready_i, txn_ready_i,
               b_valid_i, b_resp_i,
        input  req_ready_o, aw_valid_o, aw_addr_o, aw_len_o, aw_size_o,
               txn_valid_o, txn_addr_o, txn_is_head_o, txn_rmn_beat_o, txn_lbn_o,
               txn_is_final_o, b_ready_o
    );
endinterface

// File: rtl/mlsu_store_txn_sched.sv
// Store sequencer: splits one (addr, nbytes) request into 4 KiB / max-burst bounded
// AXI write bursts, issues AW, emits per-beat txn_ctrl and counts B responses.
module mlsu_store_txn_sched #(
    parameter int AxiAddrWidth   = 64,
    parameter int AxiDataWidth   = 128,
    parameter int LenWidth       = 32,
    parameter int MaxBurstBeats  = 256,
    parameter int MaxOutstanding = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    mlsu_store_txn_sched_if.master    bus,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                state_o
);
    localparam int BusBytes  = AxiDataWidth / 8;
    localparam int ByteShift = $clog2(BusBytes);
    localparam int LbnWidth  = $clog2(AxiDataWidth / 4) + 1;
    localparam int W1        = AxiAddrWidth + 1;
    localparam int OW        = $clog2(MaxOutstanding + 1);

    localparam logic [W1-1:0] AlignMask = ~W1'(BusBytes - 1);
    localparam logic [W1-1:0] PageMask  = ~W1'(4095);
    localparam logic [W1-1:0] PageSize  = W1'(4096);
    localparam logic [W1-1:0] BurstSpan = W1'(MaxBurstBeats * BusBytes);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_AW = 2'd1, S_BEAT = 2'd2, S_WAIT_B = 2'd3} state_e;

    state_e                  state_q;
    logic [OW-1:0]           outstanding_q;
    logic [W1-1:0]           end_q, burst_end_q;
    logic                    req_ready_q, aw_valid_q, txn_valid_q, b_ready_q;
    logic                    done_q, err_q;
    logic [AxiAddrWidth-1:0] aw_addr_q;
    logic [7:0]              aw_len_q, rmn_q;
    logic [AxiAddrWidth:0]   txn_addr_q;
    logic                    head_q, is_final_q;
    logic [LbnWidth-1:0]     lbn_q;

    // Burst geometry for the next burst, starting at the request address in
    // S_IDLE and at the previous burst end otherwise. Widened by one bit so
    // a request ending exactly at the top of the address space still fits.
    logic [W1-1:0]        base_c, end_c, aligned_c, page_end_c, span_end_c, burst_end_c;
    logic [7:0]           len_c;
    logic [ByteShift-1:0] last_off_c;
    logic [LbnWidth-1:0]  lbn_c;

    always_comb begin
        base_c      = (state_q == S_IDLE) ? {1'b0, bus.req_addr_i} : burst_end_q;
        end_c       = (state_q == S_IDLE) ? {1'b0, bus.req_addr_i} + W1'(bus.req_nbytes_i) : end_q;
        aligned_c   = base_c & AlignMask;
        page_end_c  = (base_c & PageMask) + PageSize;
        span_end_c  = aligned_c + BurstSpan;
        burst_end_c = end_c;
        if (page_end_c < burst_end_c) burst_end_c = page_end_c;
        if (span_end_c < burst_end_c) burst_end_c = span_end_c;
        len_c       = 8'((burst_end_c - aligned_c - W1'(1)) >> ByteShift);
        last_off_c  = burst_end_c[ByteShift-1:0] - ByteShift'(1);
        lbn_c       = {(LbnWidth-1)'(last_off_c) + (LbnWidth-1)'(1), 1'b0};
    end

    // Every channel transfers on a cycle where valid && ready are both high;
    // a producer holds valid and payload stable until that cycle.
    logic          accept, aw_hs, txn_hs, b_hs, load_burst, aw_allow;
    logic [OW-1:0] outstanding_n;

    assign accept        = (state_q == S_IDLE) && req_ready_q && bus.req_valid_i;
    assign aw_hs         = aw_valid_q && bus.aw_ready_i;
    assign txn_hs        = txn_valid_q && bus.txn_ready_i;
    assign b_hs          = b_ready_q && bus.b_valid_i && (outstanding_q != '0);
    assign outstanding_n = outstanding_q + OW'(aw_hs) - OW'(b_hs);
    assign aw_allow      = outstanding_n < OW'(MaxOutstanding);
    assign load_burst    = (accept && (bus.req_nbytes_i != '0)) ||
                           ((state_q == S_BEAT) && txn_hs && (rmn_q == '0) && !is_final_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            outstanding_q <= '0;
            end_q         <= '0;
            burst_end_q   <= '0;
            req_ready_q   <= 1'b1;
            aw_valid_q    <= 1'b0;
            txn_valid_q   <= 1'b0;
            b_ready_q     <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            aw_addr_q     <= '0;
            aw_len_q      <= '0;
            rmn_q         <= '0;
            txn_addr_q    <= '0;
            head_q        <= 1'b0;
            is_final_q    <= 1'b0;
            lbn_q         <= '0;
        end else begin
            b_ready_q     <= 1'b1;
            done_q        <= 1'b0;
            outstanding_q <= outstanding_n;
            if (b_hs && (bus.b_resp_i != 2'b00)) err_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        err_q       <= 1'b0;
                        end_q       <= end_c;
                        state_q     <= (bus.req_nbytes_i == '0) ? S_WAIT_B : S_AW;
                    end
                end
                S_AW: begin
                    if (aw_hs) begin
                        aw_valid_q  <= 1'b0;
                        txn_valid_q <= 1'b1;
                        rmn_q       <= aw_len_q;
                        head_q      <= 1'b1;
                        state_q     <= S_BEAT;
                    end else begin
                        aw_valid_q  <= aw_allow;
                    end
                end
                S_BEAT: begin
                    if (txn_hs) begin
                        if (rmn_q == '0) begin
                            txn_valid_q <= 1'b0;
                            state_q     <= is_final_q ? S_WAIT_B : S_AW;
                        end else begin
                            rmn_q  <= rmn_q - 8'd1;
                            head_q <= 1'b0;
                        end
                    end
                end
                S_WAIT_B: begin
                    if (outstanding_q == '0) begin
                        done_q      <= 1'b1;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (load_burst) begin
                aw_valid_q  <= aw_allow;
                aw_addr_q   <= base_c[AxiAddrWidth-1:0];
                aw_len_q    <= len_c;
                txn_addr_q  <= {base_c[AxiAddrWidth-1:0], 1'b0};
                lbn_q       <= lbn_c;
                is_final_q  <= (burst_end_c == end_c);
                burst_end_q <= burst_end_c;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (bus.b_valid_i && b_ready_q) assert (outstanding_q != '0);
            if (accept) assert (!(end_c[AxiAddrWidth] && (|end_c[AxiAddrWidth-1:0])));
        end
    end

    assign bus.req_ready_o    = req_ready_q;
    assign bus.aw_valid_o     = aw_valid_q;
    assign bus.aw_addr_o      = aw_addr_q;
    assign bus.aw_len_o       = aw_len_q;
    assign bus.aw_size_o      = 3'(ByteShift);
    assign bus.txn_valid_o    = txn_valid_q;
    assign bus.txn_addr_o     = txn_addr_q;
    assign bus.txn_is_head_o  = head_q;
    assign bus.txn_rmn_beat_o = rmn_q;
    assign bus.txn_lbn_o      = lbn_q;
    assign bus.txn_is_final_o = is_final_q;
    assign bus.b_ready_o      = b_ready_q;
    assign done_o             = done_q;
    assign err_o              = err_q;
    assign state_o            = state_q;
endmodule

// File: tb/tb_mlsu_store_txn_sched.sv
// Directed bench for mlsu_store_txn_sched: 16-byte bus, 256-beat bursts,
// one outstanding AW so withheld B responses visibly stall the next burst.
module tb_mlsu_store_txn_sched;
    localparam int AW = 64;
    localparam int DW = 128;
    localparam int LW = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic       err;
    logic [1:0] state;
    int         n_assert = 0;
    int         n_fail   = 0;

    mlsu_store_txn_sched_if #(.AxiAddrWidth(AW), .AxiDataWidth(DW), .LenWidth(LW)) bus ();

    mlsu_store_txn_sched #(
        .AxiAddrWidth(AW), .AxiDataWidth(DW), .LenWidth(LW),
        .MaxBurstBeats(256), .MaxOutstanding(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .done_o(done), .err_o(err), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [63:0] addr, input logic [31:0] n);
        bus.req_addr_i   = addr;
        bus.req_nbytes_i = n;
        bus.req_valid_i  = 1'b1;
        for (int i = 0; i < 100 && !bus.req_ready_o; i++) step();
        chk("req_ready", 65'(bus.req_ready_o), 65'd1);
        step();
        bus.req_valid_i  = 1'b0;
    endtask

    task automatic wait_aw(input string tag, input logic [63:0] addr, input logic [7:0] len);
        for (int i = 0; i < 100 && !bus.aw_valid_o; i++) step();
        chk({tag, "_aw_valid"}, 65'(bus.aw_valid_o), 65'd1);
        chk({tag, "_aw_addr"}, 65'(bus.aw_addr_o), 65'(addr));
        chk({tag, "_aw_len"}, 65'(bus.aw_len_o), 65'(len));
        bus.aw_ready_i = 1'b1;
        step();
        bus.aw_ready_i = 1'b0;
        chk({tag, "_txn_after_aw"}, 65'(bus.txn_valid_o), 65'd1);
    endtask

    task automatic do_beats(input string tag, input int n, input logic [64:0] addr,
                            input logic [7:0] lbn, input logic fin);
        bus.txn_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 100 && !bus.txn_valid_o; j++) step();
            chk({tag, "_txn_valid"}, 65'(bus.txn_valid_o), 65'd1);
            chk({tag, "_rmn"}, 65'(bus.txn_rmn_beat_o), 65'(n - 1 - i));
            chk({tag, "_head"}, 65'(bus.txn_is_head_o), 65'(i == 0));
            chk({tag, "_txn_addr"}, 65'(bus.txn_addr_o), addr);
            chk({tag, "_lbn"}, 65'(bus.txn_lbn_o), 65'(lbn));
            chk({tag, "_final"}, 65'(bus.txn_is_final_o), 65'(fin));
            step();
        end
        bus.txn_ready_i = 1'b0;
        chk({tag, "_txn_idle"}, 65'(bus.txn_valid_o), 65'd0);
    endtask

    task automatic send_b(input logic [1:0] resp);
        bus.b_valid_i = 1'b1;
        bus.b_resp_i  = resp;
        step();
        bus.b_valid_i = 1'b0;
        bus.b_resp_i  = 2'b00;
    endtask

    task automatic check_done(input string tag, input logic exp_err);
        chk({tag, "_done_early"}, 65'(done), 65'd0);
        step();
        chk({tag, "_done"}, 65'(done), 65'd1);
        chk({tag, "_err"}, 65'(err), 65'(exp_err));
        step();
        chk({tag, "_done_pulse"}, 65'(done), 65'd0);
        chk({tag, "_ready_again"}, 65'(bus.req_ready_o), 65'd1);
        chk({tag, "_state_idle"}, 65'(state), 65'd0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_nbytes_i = '0;
        bus.aw_ready_i   = 1'b0;
        bus.txn_ready_i  = 1'b0;
        bus.b_valid_i    = 1'b0;
        bus.b_resp_i     = 2'b00;
        step();
        step();
        chk("rst_req_ready", 65'(bus.req_ready_o), 65'd1);
        chk("rst_aw_valid", 65'(bus.aw_valid_o), 65'd0);
        chk("rst_txn_valid", 65'(bus.txn_valid_o), 65'd0);
        chk("rst_done", 65'(done), 65'd0);
        chk("rst_err", 65'(err), 65'd0);
        chk("rst_state", 65'(state), 65'd0);
        rst = 1'b0;
        step();
        chk("b_ready", 65'(bus.b_ready_o), 65'd1);
        chk("aw_size", 65'(bus.aw_size_o), 65'd4);

        // T1: single 4-beat burst, txn backpressure held for two cycles
        send_req(64'h1000, 32'd64);
        chk("t1_aw_latency", 65'(bus.aw_valid_o), 65'd1);
        step();
        chk("t1_aw_hold", 65'(bus.aw_valid_o), 65'd1);
        wait_aw("t1", 64'h1000, 8'd3);
        step();
        step();
        chk("t1_txn_hold", 65'(bus.txn_valid_o), 65'd1);
        chk("t1_rmn_hold", 65'(bus.txn_rmn_beat_o), 65'd3);
        do_beats("t1", 4, 65'h2000, 8'd32, 1'b1);
        send_b(2'b00);
        check_done("t1", 1'b0);

        // T2: request straddling a 4 KiB boundary
        send_req(64'h0FF8, 32'd16);
        wait_aw("t2a", 64'h0FF8, 8'd0);
        do_beats("t2a", 1, 65'h1FF0, 8'd32, 1'b0);
        chk("t2_aw_blocked", 65'(bus.aw_valid_o), 65'd0);
        send_b(2'b00);
        chk("t2_aw_after_b", 65'(bus.aw_valid_o), 65'd1);
        wait_aw("t2b", 64'h1000, 8'd0);
        do_beats("t2b", 1, 65'h2000, 8'd16, 1'b1);
        send_b(2'b00);
        check_done("t2", 1'b0);

        // T3: two max-length bursts, B withheld for a while between them
        send_req(64'h0, 32'd8192);
        wait_aw("t3a", 64'h0, 8'd255);
        do_beats("t3a", 256, 65'h0, 8'd32, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_aw_blocked", 65'(bus.aw_valid_o), 65'd0);
        end
        send_b(2'b00);
        wait_aw("t3b", 64'h1000, 8'd255);
        do_beats("t3b", 256, 65'h2000, 8'd32, 1'b1);
        send_b(2'b00);
        check_done("t3", 1'b0);

        // T4: zero-length request
        send_req(64'h5000, 32'd0);
        chk("t4_no_aw", 65'(bus.aw_valid_o), 65'd0);
        chk("t4_no_txn", 65'(bus.txn_valid_o), 65'd0);
        check_done("t4", 1'b0);

        // T5: SLVERR on first burst, then a clean request clears err
        send_req(64'h0FF8, 32'd16);
        wait_aw("t5a", 64'h0FF8, 8'd0);
        do_beats("t5a", 1, 65'h1FF0, 8'd32, 1'b0);
        send_b(2'b10);
        wait_aw("t5b", 64'h1000, 8'd0);
        do_beats("t5b", 1, 65'h2000, 8'd16, 1'b1);
        send_b(2'b00);
        check_done("t5", 1'b1);
        send_req(64'h2000, 32'd64);
        chk("t5_err_cleared", 65'(err), 65'd0);
        wait_aw("t5c", 64'h2000, 8'd3);
        do_beats("t5c", 4, 65'h4000, 8'd32, 1'b1);
        send_b(2'b00);
        check_done("t5c", 1'b0);

        // T6: reset in the middle of a burst with the datapath stalled
        send_req(64'h3000, 32'd32);
        wait_aw("t6", 64'h3000, 8'd1);
        chk("t6_in_beat", 65'(state), 65'd2);
        rst = 1'b1;
        step();
        chk("t6_aw_valid", 65'(bus.aw_valid_o), 65'd0);
        chk("t6_txn_valid", 65'(bus.txn_valid_o), 65'd0);
        chk("t6_done", 65'(done), 65'd0);
        chk("t6_req_ready", 65'(bus.req_ready_o), 65'd1);
        chk("t6_state", 65'(state), 65'd0);
        rst = 1'b0;
        step();
        chk("t6_b_ready", 65'(bus.b_ready_o), 65'd1);
        send_req(64'h4000, 32'd16);
        wait_aw("t6r", 64'h4000, 8'd0);
        do_beats("t6r", 1, 65'h8000, 8'd32, 1'b1);
        send_b(2'b00);
        check_done("t6r", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
